full_st_stream_tx: RTL
======================

// Module: full_st_stream_tx
// PURPOSE
// - Transmit end of the stage stream protocol (data/_fst/_vld with _rdy back-pressure) that stage controllers consume.
// - Software/testbench loads a vector into a local buffer, then the block replays it as 1..16 frames of float_24_8 samples.
// - Feeds stage_1_data / tap_in style inputs of a full_st*_ctrl; one sample per cycle when downstream is ready.
// PARAMETERS
// - WIDTH   32   sample width (float_24_8 packed)
// - DEPTH   128  buffer entries (power of 2)
// - ADDR_W  7    log2(DEPTH)
// PORTS
// - clk          in   1       clock; all state on rising edge
// - reset        in   1       asynchronous, active-low reset
// - wr_en        in   1       buffer write strobe
// - wr_addr      in   ADDR_W  buffer write address
// - wr_data      in   WIDTH   buffer write data
// - start        in   1       launch transmission (sampled only in IDLE)
// - length       in   ADDR_W  samples per frame minus 1 (0 -> 1 sample)
// - frames       in   4       frame count minus 1 (0 -> 1 frame)
// - stream       out  WIDTH   sample (float_24_8)
// - stream_fst   out  1       first sample of each frame
// - stream_vld   out  1       sample valid
// - stream_rdy   in   1       downstream accepts when vld&rdy
// - busy         out  1       high from accepted start until done
// - done         out  1       one-cycle pulse after last sample transferred
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, stream_vld=0, stream_fst=0, stream=0, busy=0, done=0, counters=0; buffer contents not cleared.
// - length/frames latched on accepted start; changes while busy ignored.
// - Buffer: synchronous write, synchronous read, 1-cycle read latency; same-address write/read in one cycle returns old data.
// - Writes accepted in every state; writes to addresses not yet read in the current run affect output.
// - FSM: IDLE -start-> RUN (busy=1 next cycle). RUN: issue read of rd_addr when the 2-entry output queue (incl. in-flight read) has a free slot.
//   After issuing addr==length of frame==frames -> DRAIN. DRAIN: no reads; when queue empty and no read in flight -> DONE.
//   DONE: done=1, busy=0 for 1 cycle -> IDLE. start in DONE/RUN/DRAIN ignored.
// - Address: rd_addr 0..length, wraps to 0 with frame_cnt+1; each frame replays buffer[0..length].
// - fst tag travels with read: set when rd_addr==0; stream_fst valid only with stream_vld.
// - Handshake: while vld&!rdy, stream/stream_fst held stable, vld stays 1; vld never drops without a transfer.
// - Throughput: with rdy held 1, first vld 2 cycles after start, then 1 sample/cycle with no bubbles incl. across frame boundaries.
// - Back-pressure: rdy low any number of cycles loses/duplicates no sample; 2-entry queue absorbs read latency.
// - Total transfers per run = (length+1)*(frames+1); done pulses exactly once, cycle after last transfer.
// - length=0,frames=0: single sample with fst=1, then done.
// - Reset mid-run: vld drops immediately (async), run abandoned; next start restarts at addr 0.
// STRUCTURE
// - Shared types package: float_24_8 (existing), stream_tx_state_t {IDLE,RUN,DRAIN,DONE}.
// - One sub-module: full_st_stream_tx_skid (2-entry {data,fst} FIFO, push/pop/count, registered outputs).
// - Buffer inferred as simple dual-port RAM inside top.
// TESTING
// - Write buf[i]=i+1 (i=0..7), length=7, frames=0, rdy=1 -> 8 transfers 1..8, fst on 1 only, vld contiguous, done 1 cycle after 8.
// - Same buffer, length=3, frames=2, rdy=1 -> 1,2,3,4 x3, fst on each 1, no bubbles, 12 transfers, one done pulse.
// - length=7, rdy random 50% -> transfers still 1..8 in order; data/fst stable whenever vld&!rdy.
// - length=0, frames=0, buf[0]=0x3F800000 -> single transfer 0x3F800000 fst=1, done next cycle, busy low.
// - Pulse start while busy, change length mid-run -> ignored; counts match latched values.
// - Assert reset after 3 transfers of 8 -> vld/busy 0 immediately; restart -> full 1..8 from addr 0.

Source files
------------

// File: rtl/full_st_stream_tx_pkg.sv
// Shared types for the stage stream transmitter: sample format, FSM states
// and the {data,fst} entry carried through the output queue.
package full_st_stream_tx_pkg;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] float_24_8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stream_tx_state_t;

  typedef struct packed {
    float_24_8 data;
    logic      fst;
  } stream_entry_t;
endpackage

// File: rtl/full_st_stream_tx_if.sv
// Stage stream link: sample, first-of-frame tag, valid, and ready back-pressure.
interface full_st_stream_tx_if;
  full_st_stream_tx_pkg::float_24_8 stream;
  logic stream_fst;
  logic stream_vld;
  logic stream_rdy;

  modport master (output stream, output stream_fst, output stream_vld, input stream_rdy);
  modport slave  (input stream, input stream_fst, input stream_vld, output stream_rdy);
endinterface

// File: rtl/full_st_stream_tx_skid.sv
// Two-entry {data,fst} FIFO; head entry is a flop so the stream output is registered.
module full_st_stream_tx_skid
  import full_st_stream_tx_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  stream_entry_t push_entry,
  input  logic          pop,
  output stream_entry_t head,
  output logic          out_vld,
  output logic [1:0]    count
);
  stream_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          do_pop, do_push;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != 2'd0);
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_entry;
        else               e1_d = push_entry;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = push_entry;
        end else begin
          e0_d = e1_q;
          e1_d = push_entry;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head    = e0_q;
  assign out_vld = (cnt_q != 2'd0);
  assign count   = cnt_q;
endmodule

// File: rtl/full_st_stream_tx.sv
// Replays buffer[0..length] as frames+1 frames on the stage stream, with
// ready back-pressure absorbed by a 2-entry queue behind a 1-cycle RAM.
module full_st_stream_tx
  import full_st_stream_tx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  float_24_8         wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  input  logic [3:0]        frames,
  output logic              busy,
  output logic              done,
  full_st_stream_tx_if.master tx
);
  stream_tx_state_t  state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, len_q, len_d;
  logic [3:0]        frame_cnt_q, frame_cnt_d, frm_q, frm_d;
  logic              rd_vld_q, rd_vld_d, rd_fst_q, rd_fst_d;
  logic              rd_en, pop, skid_vld;
  logic [1:0]        skid_cnt;
  logic [2:0]        occ_after;
  stream_entry_t     head;

  float_24_8 mem [DEPTH];
  float_24_8 rd_data_q;

  assign pop = skid_vld && tx.stream_rdy;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    frame_cnt_d = frame_cnt_q;
    len_d       = len_q;
    frm_d       = frm_q;
    rd_en       = 1'b0;
    rd_vld_d    = 1'b0;
    rd_fst_d    = rd_fst_q;
    // Queue occupancy after this cycle's pop, counting the read already in flight.
    occ_after   = {1'b0, skid_cnt} + {2'b00, rd_vld_q} - {2'b00, pop};
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          len_d       = length;
          frm_d       = frames;
          rd_addr_d   = '0;
          frame_cnt_d = '0;
        end
      end
      RUN: begin
        if (occ_after < 3'd2) begin
          rd_en    = 1'b1;
          rd_vld_d = 1'b1;
          rd_fst_d = (rd_addr_q == '0);
          if (rd_addr_q == len_q) begin
            rd_addr_d = '0;
            if (frame_cnt_q == frm_q) state_d = DRAIN;
            else                      frame_cnt_d = frame_cnt_q + 4'd1;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      // Leave as soon as the final pop empties the queue, so done lands the next cycle.
      DRAIN:   if (!rd_vld_q && occ_after == 3'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      frame_cnt_q <= '0;
      len_q       <= '0;
      frm_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_fst_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      frame_cnt_q <= frame_cnt_d;
      len_q       <= len_d;
      frm_q       <= frm_d;
      rd_vld_q    <= rd_vld_d;
      rd_fst_q    <= rd_fst_d;
    end
  end

  // NOTE: the buffer has no reset so it maps onto block RAM; contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr_q];
  end

  full_st_stream_tx_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (rd_vld_q),
    .push_entry ('{data: rd_data_q, fst: rd_fst_q}),
    .pop        (pop),
    .head       (head),
    .out_vld    (skid_vld),
    .count      (skid_cnt)
  );

  assign tx.stream     = head.data;
  assign tx.stream_fst = head.fst && skid_vld;
  assign tx.stream_vld = skid_vld;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
endmodule
